rx_pair_framer: RTL and testbench

- Upstream feeder for the 64-state branch-metric array of the rate-1/2 hard-decision Viterbi decoder.
- Accepts the received hard-decision bit stream serially with a valid/ready handshake.
- Groups consecutive bits into 2-bit symbol pairs and delimits frames of FRAME_PAIRS pairs.
- Presents each pair as rx_pair to every BMC instance, with valid/ready backpressure from the ACS stage.

---
 rtl/rx_pair_framer.sv | 147 ++++++++++++++
 tb/tb_rx_pair_framer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_pair_framer.sv
// rtl/rx_pair_framer.sv - serial hard-decision bits to framed 2-bit symbol pairs
// Feeds the branch-metric stage; one output register with valid/ready backpressure.
module rx_pair_framer #(
    parameter int FRAME_PAIRS = 256,
    parameter int CNT_W       = $clog2(FRAME_PAIRS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       din_sof,
    output logic       din_ready,
    output logic [1:0] rx_pair,
    output logic       pair_valid,
    input  logic       pair_ready,
    output logic       pair_sof,
    output logic       pair_eof,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF0 = 2'd1,
        HALF1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PAIRS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;

    logic [1:0]       pair_q, pair_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             err_q, err_d;

    logic             accept;
    logic             load;
    logic             restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        load    = 1'b0;
        accept  = din_valid & din_ready;
        restart = accept & din_sof & (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept && din_sof) begin
                    held_d  = din;
                    cnt_d   = '0;
                    state_d = HALF1;
                end
            end
            HALF0: begin
                if (accept) begin
                    held_d  = din;
                    state_d = HALF1;
                    if (din_sof) begin
                        cnt_d = '0;
                    end
                end
            end
            HALF1: begin
                if (accept) begin
                    if (din_sof) begin
                        // Abort: the sof bit becomes the held first bit of pair 0.
                        held_d = din;
                        cnt_d  = '0;
                    end else begin
                        load = 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = HALF0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        din_ready = 1'b1;
        if (state_q == HALF1) begin
            din_ready = !valid_q | pair_ready;
        end
    end

    always_comb begin
        pair_d  = pair_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        valid_d = valid_q & ~pair_ready;
        err_d   = restart;
        if (load) begin
            pair_d  = {held_q, din};
            valid_d = 1'b1;
            sof_d   = (cnt_q == '0);
            eof_d   = (cnt_q == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q  <= 2'b00;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
        end
    end

    assign rx_pair    = pair_q;
    assign pair_valid = valid_q;
    assign pair_sof   = sof_q;
    assign pair_eof   = eof_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_rx_pair_framer.sv
// tb/tb_rx_pair_framer.sv - directed and random checks of rx_pair_framer against a bit-stream model
module tb_rx_pair_framer;

    localparam int FP = 4;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       din_sof;
    logic       din_ready;
    logic [1:0] rx_pair;
    logic       pair_valid;
    logic       pair_ready;
    logic       pair_sof;
    logic       pair_eof;
    logic       frame_err;

    rx_pair_framer #(.FRAME_PAIRS(FP)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_ready  (din_ready),
        .rx_pair    (rx_pair),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_sof   (pair_sof),
        .pair_eof   (pair_eof),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] p;
        logic       s;
        logic       e;
    } pair_t;

    int    total = 0;
    int    bad   = 0;
    int    err_seen = 0;

    // Model: frame content as a count of bits since sof, plus a queue of
    // pairs produced but not yet taken by the consumer.
    pair_t q[$];
    bit    in_frame = 0;
    int    nbits    = 0;
    logic  prev_bit = 1'b0;
    logic  err_exp  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_frame = 0;
        nbits    = 0;
        prev_bit = 1'b0;
        err_exp  = 1'b0;
    endtask

    task automatic step(input logic b, input logic v, input logic s, input logic r);
        pair_t np;
        logic  exp_rdy;
        int    idx;
        @(negedge clk);
        check("pair_valid", pair_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("rx_pair", rx_pair, q[0].p);
            check("pair_sof", pair_sof, q[0].s);
            check("pair_eof", pair_eof, q[0].e);
        end
        check("frame_err", frame_err, err_exp);
        if (frame_err) err_seen++;
        din        = b;
        din_valid  = v;
        din_sof    = s;
        pair_ready = r;
        #1;
        exp_rdy = !(in_frame && (nbits % 2 == 1)) || (q.size() == 0) || r;
        check("din_ready", din_ready, exp_rdy);
        if (q.size() != 0 && r) void'(q.pop_front());
        err_exp = 1'b0;
        if (v && exp_rdy) begin
            if (s) begin
                err_exp  = in_frame;
                in_frame = 1;
                nbits    = 1;
                prev_bit = b;
            end else if (in_frame) begin
                nbits++;
                if (nbits % 2 == 0) begin
                    idx  = nbits / 2 - 1;
                    np.p = {prev_bit, b};
                    np.s = (idx == 0);
                    np.e = (idx == FP - 1);
                    q.push_back(np);
                    if (idx == FP - 1) begin
                        in_frame = 0;
                        nbits    = 0;
                    end
                end else begin
                    prev_bit = b;
                end
            end
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b1, (i == 0), r);
        end
    endtask

    initial begin
        int errs_before;
        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        din_sof    = 1'b0;
        pair_ready = 1'b0;
        model_reset();
        #1;
        check("rst_pair_valid", pair_valid, 0);
        check("rst_rx_pair", rx_pair, 0);
        check("rst_sof_eof_err", {pair_sof, pair_eof, frame_err}, 0);
        check("rst_din_ready", din_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame: 11 01 10 00 at full rate
        send_bits(16'b11011000, 8, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Pre-frame garbage then a frame
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1);
        send_bits(16'b01101100, 8, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: consumer stalls after the first pair
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(i[0], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(~i[1], 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Premature sof on the third pair's second bit
        errs_before = err_seen;
        send_bits(16'b10011, 5, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(i[0], 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("premature_err_pulses", err_seen - errs_before, 1);

        // Back-to-back frames, no gap between eof and next sof
        errs_before = err_seen;
        send_bits(16'b00110110, 8, 1'b1);
        send_bits(16'b11100100, 8, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b_no_err", err_seen - errs_before, 0);

        // Reset mid-frame while in HALF1 with a pair pending
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_pending", pair_valid, 1);
        din_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("mid_rst_pair_valid", pair_valid, 0);
        check("mid_rst_rx_pair", rx_pair, 0);
        check("mid_rst_flags", {pair_sof, pair_eof, frame_err}, 0);
        check("mid_rst_din_ready", din_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_bits(16'b10100101, 8, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
